// File: rtl/spi_frame_ctrl_pkg.sv
// Shared constants and types for the SPI frame command sequencer.
`ifndef SPI_WIDHT
`define SPI_WIDHT 16
`endif

package spi_frame_ctrl_pkg;
  localparam int WIDTH     = `SPI_WIDHT;
  localparam int REG_IDX_W = 3;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WR    = 4'h1;
  localparam logic [3:0] OP_RD    = 4'h2;
  localparam logic [3:0] OP_FRAME = 4'h3;

  localparam logic [WIDTH-1:0] REPLY_NOT_READY = 16'hDEAD;
  localparam logic [WIDTH-1:0] REPLY_BAD_OP    = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_FETCH,
    ST_LOAD,
    ST_STREAM
  } state_t;

  function automatic logic [WIDTH-1:0] status_word(input logic ready, input logic [7:0] reg0);
    return {ready, 7'b0, reg0};
  endfunction
endpackage

// File: rtl/spi_frame_ctrl_reg_bank.sv
// NREG x 8-bit configuration registers: one write port, indexed read, flat bus view.
module spi_reg_bank
  import spi_frame_ctrl_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] idx,
  input  logic [7:0]           wr_data,
  output logic [7:0]           rd_data,
  output logic [7:0]           reg0,
  output logic [NREG*8-1:0]    bus
);
  logic [7:0] regs [NREG];

  // NOTE: this bank is a few flops rather than a RAM, so it takes the async reset and the bus comes up all-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NREG; k++)
        if (idx == REG_IDX_W'(k)) regs[k] <= wr_data;
    end
  end

  // Indices beyond NREG read back as zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NREG; k++)
      if (idx == REG_IDX_W'(k)) rd_data = regs[k];
  end

  assign reg0 = regs[0];

  for (genvar g = 0; g < NREG; g++) begin : g_bus
    assign bus[8*g +: 8] = regs[g];
  end
endmodule

// File: rtl/spi_frame_ctrl.sv
// Command sequencer behind the SPI slave word interface: register access,
// frame streaming from pixel memory and the frame-ready/done handshake.
module spi_frame_ctrl
  import spi_frame_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int FRAME_WORDS = 19200,
  parameter int NREG        = 8
) (
  input  logic              clkIN,
  input  logic              reset_spi,
  input  logic              nSSIN,
  input  logic              wordValidIN,
  input  logic [WIDTH-1:0]  rxWordIN,
  output logic [WIDTH-1:0]  txWordOUT,
  output logic              txLoadOUT,
  output logic [ADDR_W-1:0] memAddrOUT,
  output logic              memRdOUT,
  input  logic [WIDTH-1:0]  memDataIN,
  input  logic              frameReadyIN,
  output logic              frameDoneOUT,
  output logic [NREG*8-1:0] regBusOUT
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_t              state, state_d;
  logic [WIDTH-1:0]    tx_word_d;
  logic                tx_load_d, mem_rd_d, frame_done_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                ready;
  logic                wr_en;
  logic [3:0]          opcode;
  logic [REG_IDX_W-1:0] reg_idx;
  logic [7:0]          rd_data, reg0, reg0_after_wr;
  logic                unused_rx_bit;

  assign opcode        = rxWordIN[15:12];
  assign reg_idx       = rxWordIN[10:8];
  assign unused_rx_bit = rxWordIN[11];
  // A write to reg0 must already show in the status word loaded alongside it.
  assign reg0_after_wr = (reg_idx == '0) ? rxWordIN[7:0] : reg0;

  spi_reg_bank #(.NREG(NREG)) u_reg_bank (
    .clk     (clkIN),
    .rst     (reset_spi),
    .wr_en   (wr_en),
    .idx     (reg_idx),
    .wr_data (rxWordIN[7:0]),
    .rd_data (rd_data),
    .reg0    (reg0),
    .bus     (regBusOUT)
  );

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    tx_word_d    = txWordOUT;
    tx_load_d    = 1'b0;
    mem_addr_d   = memAddrOUT;
    mem_rd_d     = 1'b0;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    if (nSSIN) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_d   = ST_CMD;
          tx_word_d = status_word(ready, reg0);
          tx_load_d = 1'b1;
        end
        ST_CMD: if (wordValidIN) begin
          tx_load_d = 1'b1;
          case (opcode)
            OP_NOP: tx_word_d = status_word(ready, reg0);
            OP_WR: begin
              wr_en     = 1'b1;
              tx_word_d = status_word(ready, reg0_after_wr);
            end
            OP_RD: tx_word_d = {8'h00, rd_data};
            OP_FRAME: begin
              if (ready) begin
                tx_load_d  = 1'b0;
                mem_addr_d = '0;
                mem_rd_d   = 1'b1;
                state_d    = ST_FETCH;
              end else begin
                tx_word_d = REPLY_NOT_READY;
              end
            end
            default: tx_word_d = REPLY_BAD_OP;
          endcase
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          tx_word_d = memDataIN;
          tx_load_d = 1'b1;
          state_d   = ST_STREAM;
        end
        ST_STREAM: if (wordValidIN) begin
          if (memAddrOUT == LAST_ADDR) begin
            frame_done_d = 1'b1;
            tx_word_d    = status_word(ready, reg0);
            tx_load_d    = 1'b1;
            state_d      = ST_CMD;
          end else begin
            mem_addr_d = memAddrOUT + 1'b1;
            mem_rd_d   = 1'b1;
            state_d    = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clkIN or posedge reset_spi) begin
    if (reset_spi) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // The capture path's new-frame pulse beats a same-cycle frame-done clear.
  always_ff @(posedge clkIN or posedge reset_spi) begin
    if (reset_spi) begin
      txWordOUT    <= '0;
      txLoadOUT    <= 1'b0;
      memAddrOUT   <= '0;
      memRdOUT     <= 1'b0;
      frameDoneOUT <= 1'b0;
      ready        <= 1'b0;
    end else begin
      txWordOUT    <= tx_word_d;
      txLoadOUT    <= tx_load_d;
      memAddrOUT   <= mem_addr_d;
      memRdOUT     <= mem_rd_d;
      frameDoneOUT <= frame_done_d;
      ready        <= frameReadyIN | (ready & ~frameDoneOUT);
    end
  end
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: host-level model with expectation queues plus directed literals.
module tb_spi_frame_ctrl;
  localparam int FW  = 19200;
  localparam int SFW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, nss, wv, frame_ready, tx_load, mem_rd, frame_done;
  logic [15:0] rx, tx, mem_data = '0;
  logic [14:0] addr;
  logic [63:0] reg_bus;

  spi_frame_ctrl dut (
    .clkIN(clk), .reset_spi(rst), .nSSIN(nss), .wordValidIN(wv), .rxWordIN(rx),
    .txWordOUT(tx), .txLoadOUT(tx_load), .memAddrOUT(addr), .memRdOUT(mem_rd),
    .memDataIN(mem_data), .frameReadyIN(frame_ready), .frameDoneOUT(frame_done),
    .regBusOUT(reg_bus)
  );

  // Short-frame instance used to reach frame end cheaply for the set-wins case.
  logic        s_nss, s_wv, s_fr, s_load, s_rd, s_done;
  logic [15:0] s_rx, s_tx, s_mem = '0;
  logic [14:0] s_addr;
  logic [63:0] s_bus;

  spi_frame_ctrl #(.FRAME_WORDS(SFW)) dut_s (
    .clkIN(clk), .reset_spi(rst), .nSSIN(s_nss), .wordValidIN(s_wv), .rxWordIN(s_rx),
    .txWordOUT(s_tx), .txLoadOUT(s_load), .memAddrOUT(s_addr), .memRdOUT(s_rd),
    .memDataIN(s_mem), .frameReadyIN(s_fr), .frameDoneOUT(s_done),
    .regBusOUT(s_bus)
  );

  always @(posedge clk) if (mem_rd) mem_data <= 16'h1000 + {1'b0, addr};
  always @(posedge clk) if (s_rd)   s_mem    <= 16'h1000 + {1'b0, s_addr};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Host-level model: registers, ready flag, stream position, and queued expectations.
  typedef struct { logic [15:0] val; int due; } exp_t;
  exp_t       exp_tx[$];
  exp_t       exp_rd[$];
  int         exp_done[$];
  logic [7:0] m_regs [8];
  logic       m_ready;
  bit         m_stream;
  int         m_addr;

  function automatic logic [15:0] status(input logic [7:0] r0);
    return {m_ready, 7'b0, r0};
  endfunction

  function automatic logic [15:0] pixel(input int a);
    return 16'(16'h1000 + a);
  endfunction

  function automatic logic [63:0] m_bus();
    logic [63:0] b;
    for (int k = 0; k < 8; k++) b[8*k +: 8] = m_regs[k];
    return b;
  endfunction

  task automatic push_tx(input logic [15:0] v, input int due);
    exp_t e;
    e.val = v; e.due = due;
    exp_tx.push_back(e);
  endtask

  task automatic push_rd(input int a, input int due);
    exp_t e;
    e.val = 16'(a); e.due = due;
    exp_rd.push_back(e);
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (!rst) begin
      if (tx_load) begin
        if (exp_tx.size() == 0) check("tx_load_spurious", 64'(tx_load), 64'd0);
        else begin
          e = exp_tx.pop_front();
          check("tx_word", 64'(tx), 64'(e.val));
          check("tx_load_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (exp_tx.size() > 0 && exp_tx[0].due < cyc) begin
        check("tx_load_missing", 64'(tx_load), 64'd1);
        void'(exp_tx.pop_front());
      end
      if (mem_rd) begin
        if (exp_rd.size() == 0) check("mem_rd_spurious", 64'(mem_rd), 64'd0);
        else begin
          e = exp_rd.pop_front();
          check("mem_addr", 64'(addr), 64'(e.val));
          check("mem_rd_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (exp_rd.size() > 0 && exp_rd[0].due < cyc) begin
        check("mem_rd_missing", 64'(mem_rd), 64'd1);
        void'(exp_rd.pop_front());
      end
      if (frame_done) begin
        if (exp_done.size() == 0) check("frame_done_spurious", 64'(frame_done), 64'd0);
        else check("frame_done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
      end else if (exp_done.size() > 0 && exp_done[0] < cyc) begin
        check("frame_done_missing", 64'(frame_done), 64'd1);
        void'(exp_done.pop_front());
      end
      check("reg_bus", reg_bus, m_bus());
    end
  end

  task automatic select();
    nss = 1'b0;
    m_stream = 0;
    push_tx(status(m_regs[0]), cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    int k;
    bit do_wr, end_frame;
    do_wr = 0; end_frame = 0;
    k = cyc + 1;
    wv = 1'b1; rx = w;
    if (!m_stream) begin
      case (w[15:12])
        4'h0: push_tx(status(m_regs[0]), k);
        4'h1: begin
          do_wr = 1;
          push_tx(status((w[10:8] == 3'd0) ? w[7:0] : m_regs[0]), k);
        end
        4'h2: push_tx({8'h00, m_regs[w[10:8]]}, k);
        4'h3: begin
          if (m_ready) begin
            m_stream = 1; m_addr = 0;
            push_rd(0, k);
            push_tx(pixel(0), k + 2);
          end else push_tx(16'hDEAD, k);
        end
        default: push_tx(16'hFFFF, k);
      endcase
    end else if (m_addr == FW - 1) begin
      push_tx(status(m_regs[0]), k);
      exp_done.push_back(k);
      m_stream = 0; end_frame = 1;
    end else begin
      m_addr++;
      push_rd(m_addr, k);
      push_tx(pixel(m_addr), k + 2);
    end
    @(posedge clk); #1;
    wv = 1'b0; rx = '0;
    if (do_wr) m_regs[w[10:8]] = w[7:0];
    repeat (m_stream ? 2 : 1) @(posedge clk);
    #1;
    if (end_frame) m_ready = 1'b0;
  endtask

  task automatic pulse_ready();
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic s_send(input logic [15:0] w);
    s_wv = 1'b1; s_rx = w;
    @(posedge clk); #1;
    s_wv = 1'b0; s_rx = '0;
  endtask

  initial begin
    #900000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst = 1'b1; nss = 1'b1; wv = 1'b0; rx = '0; frame_ready = 1'b0;
    s_nss = 1'b1; s_wv = 1'b0; s_rx = '0; s_fr = 1'b0;
    for (int k = 0; k < 8; k++) m_regs[k] = '0;
    m_ready = 1'b0; m_stream = 0; m_addr = 0;
    repeat (3) @(posedge clk); #1;
    check("reset_tx_word", 64'(tx), 64'h0);
    check("reset_tx_load", 64'(tx_load), 64'h0);
    check("reset_mem_addr", 64'(addr), 64'h0);
    check("reset_mem_rd", 64'(mem_rd), 64'h0);
    check("reset_frame_done", 64'(frame_done), 64'h0);
    check("reset_reg_bus", reg_bus, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    select();
    check("status_after_select", 64'(tx), 64'h0000);
    send_word(16'h1305);
    send_word(16'h2300);
    check("read_reg3", 64'(tx), 64'h0005);
    check("reg_bus_reg3", reg_bus, 64'h0000_0000_0500_0000);
    send_word(16'h3000);
    check("frame_not_ready", 64'(tx), 64'hDEAD);
    send_word(16'h7000);
    check("undefined_opcode", 64'(tx), 64'hFFFF);

    pulse_ready();
    send_word(16'h10AB);
    check("status_write_reg0", 64'(tx), 64'h80AB);
    send_word(16'h3000);
    check("first_pixel", 64'(tx), 64'h1000);
    for (int i = 1; i < FW; i++) send_word(16'h17EE);
    check("last_pixel", 64'(tx), 64'h5AFF);
    send_word(16'h17EE);
    check("frame_end_status", 64'(tx), 64'h80AB);
    send_word(16'h0000);
    check("ready_cleared", 64'(tx), 64'h00AB);
    send_word(16'h3000);
    check("frame_after_done", 64'(tx), 64'hDEAD);

    pulse_ready();
    send_word(16'h3000);
    for (int i = 1; i <= 100; i++) send_word(16'h17EE);
    check("abort_point_pixel", 64'(tx), 64'h1064);
    nss = 1'b1; wv = 1'b1; rx = 16'h3000; m_stream = 0;
    @(posedge clk); #1;
    wv = 1'b0; rx = '0;
    repeat (2) @(posedge clk); #1;
    select();
    check("status_after_abort", 64'(tx), 64'h80AB);
    send_word(16'h3000);
    check("restart_addr", 64'(addr), 64'h0);
    check("restart_first_pixel", 64'(tx), 64'h1000);
    send_word(16'h17EE);
    send_word(16'h17EE);

    // Short-frame instance: frame-ready arriving with frame-done keeps the flag set.
    s_nss = 1'b0;
    @(posedge clk); #1;
    check("s_select_load", 64'(s_load), 64'h1);
    check("s_select_status", 64'(s_tx), 64'h0000);
    s_fr = 1'b1;
    @(posedge clk); #1;
    s_fr = 1'b0;
    s_send(16'h3000);
    check("s_fetch_rd", 64'(s_rd), 64'h1);
    check("s_fetch_addr", 64'(s_addr), 64'h0);
    repeat (2) @(posedge clk); #1;
    check("s_first_load", 64'(s_load), 64'h1);
    check("s_first_pixel", 64'(s_tx), 64'h1000);
    for (int i = 1; i < SFW; i++) begin
      s_send(16'h0000);
      check("s_stream_addr", 64'(s_addr), 64'(i));
      repeat (2) @(posedge clk); #1;
      check("s_stream_pixel", 64'(s_tx), 64'(16'h1000 + i));
    end
    s_send(16'h0000);
    check("s_frame_done", 64'(s_done), 64'h1);
    check("s_end_status", 64'(s_tx), 64'h8000);
    s_fr = 1'b1;
    @(posedge clk); #1;
    s_fr = 1'b0;
    check("s_frame_done_single", 64'(s_done), 64'h0);
    @(posedge clk); #1;
    s_send(16'h0000);
    check("s_set_wins_status", 64'(s_tx), 64'h8000);
    s_send(16'h3000);
    check("s_refetch_rd", 64'(s_rd), 64'h1);
    check("s_refetch_addr", 64'(s_addr), 64'h0);
    check("s_reg_bus", s_bus, 64'h0);

    check("tx_queue_drained", 64'(exp_tx.size()), 64'h0);
    check("rd_queue_drained", 64'(exp_rd.size()), 64'h0);
    check("done_queue_drained", 64'(exp_done.size()), 64'h0);

    // Asynchronous reset in the middle of a fetch.
    wv = 1'b1; rx = 16'h17EE;
    @(posedge clk); #1;
    wv = 1'b0; rx = '0;
    #2;
    rst = 1'b1;
    #1;
    check("midreset_tx_word", 64'(tx), 64'h0);
    check("midreset_mem_rd", 64'(mem_rd), 64'h0);
    check("midreset_mem_addr", 64'(addr), 64'h0);
    check("midreset_reg_bus", reg_bus, 64'h0);
    check("midreset_s_tx", 64'(s_tx), 64'h0);
    exp_tx.delete(); exp_rd.delete(); exp_done.delete();
    for (int k = 0; k < 8; k++) m_regs[k] = '0;
    m_ready = 1'b0; m_stream = 0;
    nss = 1'b1; s_nss = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("post_reset_tx_load", 64'(tx_load), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Command sequencer behind the SPI slave word interface, running in the system clock domain. It decodes host command words and maintains a small configuration register bank. It streams a thermal frame out of pixel memory word-by-word, always presenting the next TX word before the host clocks it. It also owns the frame-ready/frame-done handshake with the capture path.

Parameters:
WIDTH, 16, SPI word width; equals `SPI_WIDHT
ADDR_W, 15, pixel memory address width
FRAME_WORDS, 19200, words per frame (160x120 pixels)
NREG, 8, number of 8-bit configuration registers

Ports:
clkIN  in  1  system clock
reset_spi  in  1  asynchronous reset, active-high
nSSIN  in  1  slave select, already synchronised to clkIN, active-low
wordValidIN  in  1  one-cycle pulse: a full RX word completed (synchronised)
rxWordIN  in  WIDTH  received word; valid while wordValidIN=1
txWordOUT  out  WIDTH  word the SPI slave shifts out next
txLoadOUT  out  1  one-cycle pulse: slave copies txWordOUT into its shift register
memAddrOUT  out  ADDR_W  pixel memory read address
memRdOUT  out  1  read strobe; memDataIN valid exactly 1 cycle later
memDataIN  in  WIDTH  pixel memory read data
frameReadyIN  in  1  one-cycle pulse from capture: new frame stored
frameDoneOUT  out  1  one-cycle pulse: full frame streamed
regBusOUT  out  NREG*8  register bank; reg k at bits [8k+7:8k]

Behaviour:
- Reset (async, active-high): state=IDLE; txWordOUT=0; txLoadOUT=0; memAddrOUT=0; memRdOUT=0; frameDoneOUT=0; regBusOUT=0; ready flag=0.
- The ready flag sets on frameReadyIN. It clears on frameDoneOUT. If both occur in the same cycle, set wins.
- States: IDLE, CMD, FETCH, LOAD, STREAM.
- IDLE: waits for nSSIN=0. On entry to CMD, loads the status word and pulses txLoadOUT. Status word = {ready flag, 7'b0, reg0}.
- CMD: each wordValidIN decodes rxWordIN[15:12]:
  - 0x0 NOP: reload the status word and pulse txLoadOUT.
  - 0x1 WRITE: reg[rxWordIN[10:8]] <= rxWordIN[7:0]; the register updates the cycle after wordValidIN. Then reload the status word.
  - 0x2 READ: txWordOUT = {8'h00, reg[rxWordIN[10:8]]}; pulse txLoadOUT 1 cycle after wordValidIN.
  - 0x3 FRAME: if the ready flag is set, memAddrOUT=0, memRdOUT=1, go to FETCH. If the ready flag is clear, txWordOUT=16'hDEAD, pulse txLoadOUT and stay in CMD.
  - Any other opcode: txWordOUT=16'hFFFF, pulse txLoadOUT.
- FETCH: one wait cycle for memory latency, then go to LOAD.
- LOAD: txWordOUT<=memDataIN, pulse txLoadOUT, go to STREAM.
- STREAM: on wordValidIN (content ignored):
  - If memAddrOUT==FRAME_WORDS-1: pulse frameDoneOUT, load the status word, go to CMD.
  - Otherwise: memAddrOUT+1, memRdOUT=1, go to FETCH.
- Latency: from wordValidIN to txLoadOUT is 1 cycle in CMD and 3 cycles while streaming. The next TX word is therefore ready well inside one SPI word time for any clkIN >= 4x SCK.
- Address arithmetic: unsigned ADDR_W bits. The address never wraps, because it stops at FRAME_WORDS-1.
- Strobes: memRdOUT and txLoadOUT are single-cycle only.
- nSSIN=1 in any state: go to IDLE next cycle.
  - Abort mid-frame: no frameDoneOUT; the ready flag is kept, so the host may re-request the frame.
  - A wordValidIN in the same cycle as nSSIN=1 is ignored.
- Reset asserted mid-transaction: immediate IDLE with all outputs at their reset values.

Decomposition:
- Shared package/define file: WIDTH (`SPI_WIDHT), opcode constants (OP_NOP, OP_WR, OP_RD, OP_FRAME), reply constants (16'hDEAD, 16'hFFFF), state encodings.
- Sub-module spi_reg_bank: NREG x 8 registers with a write port, an indexed read mux and the flat regBusOUT.

Test Plan:
- Reset, then nSSIN=0 -> txLoadOUT pulse with txWordOUT=16'h0000; regBusOUT=0.
- Word 16'h1305, then 16'h2300 -> reg3=8'h05; after the second word txWordOUT=16'h0005.
- frameReadyIN pulse, then 16'h3000 with memory returning addr+16'h1000 -> memAddrOUT 0..19199 in order; TX words 16'h1000..; frameDoneOUT once after word 19200; ready flag cleared.
- 16'h3000 with ready flag clear -> txWordOUT=16'hDEAD; no memRdOUT.
- Frame streaming, nSSIN=1 after 100 words -> IDLE; no frameDoneOUT; a new 16'h3000 restarts at memAddrOUT=0.
- frameReadyIN coincident with frameDoneOUT -> ready flag remains 1; an undefined opcode 16'h7000 -> 16'hFFFF.
